// File: rtl/tetris_playfield_pkg.sv
// Shared types and default board geometry for the playfield block.
package tetris_pkg;

  localparam int DEF_BOARD_W   = 10;
  localparam int DEF_BOARD_H   = 23;
  localparam int DEF_VISIBLE_H = 20;

  // Lock/clear sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tetris_playfield_cell_probe.sv
// Single-cell collision probe: a cell collides if it is off the board or
// already occupied.
module tetris_cell_probe import tetris_pkg::*; #(
  parameter int  BOARD_W = DEF_BOARD_W,
  parameter int  BOARD_H = DEF_BOARD_H,
  localparam int X_W     = $clog2(BOARD_W),
  localparam int Y_W     = $clog2(BOARD_H)
) (
  input  logic [X_W-1:0]                    x,
  input  logic [Y_W-1:0]                    y,
  input  logic [BOARD_H-1:0][BOARD_W-1:0]   board,
  output logic                              hit
);

  // Out-of-range cells (including wrapped negatives) always collide; the
  // board is only indexed when the coordinate is known to be valid.
  always_comb begin
    hit = 1'b1;
    if (32'(x) < BOARD_W && 32'(y) < BOARD_H)
      hit = board[y][x];
  end

endmodule

// File: rtl/tetris_playfield.sv
// Tetris playfield: board storage, piece lock, line-clear compaction,
// collision query and display read-out.
module tetris_playfield import tetris_pkg::*; #(
  parameter int  BOARD_W   = DEF_BOARD_W,
  parameter int  BOARD_H   = DEF_BOARD_H,
  parameter int  VISIBLE_H = DEF_VISIBLE_H,
  localparam int X_W       = $clog2(BOARD_W),
  localparam int Y_W       = $clog2(BOARD_H)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lock_valid,
  output logic                 lock_ready,
  input  logic [4*X_W-1:0]     lock_x,
  input  logic [4*Y_W-1:0]     lock_y,
  input  logic                 query_valid,
  input  logic [4*X_W-1:0]     query_x,
  input  logic [4*Y_W-1:0]     query_y,
  output logic                 query_hit,
  output logic                 query_hit_valid,
  input  logic [Y_W-1:0]       rd_row,
  output logic [BOARD_W-1:0]   rd_data,
  output logic                 clear_done,
  output logic [2:0]           lines_cleared,
  output logic                 top_out,
  output logic                 bad_lock
);

  state_t                            state, state_next;
  logic [3:0][X_W-1:0]               cell_x;
  logic [3:0][Y_W-1:0]               cell_y;
  logic [BOARD_H-1:0][BOARD_W-1:0]   board, board_next, board_up;
  logic [Y_W:0]                      scan_row, scan_row_next;
  logic [2:0]                        clr_cnt;
  logic                              row_full;
  logic [3:0]                        cell_in, cell_top, probe_hit;

  // Board shifted down by one row with zeros entering at the top; rows at
  // and above the cleared row take this view.
  assign board_up = {{BOARD_W{1'b0}}, board[BOARD_H-1:1]};

  // Range and top-out classification of the latched piece cells.
  always_comb begin
    cell_in  = '0;
    cell_top = '0;
    for (int c = 0; c < 4; c++) begin
      cell_in[c]  = (32'(cell_x[c]) < BOARD_W) && (32'(cell_y[c]) < BOARD_H);
      cell_top[c] = cell_in[c] && (32'(cell_y[c]) >= VISIBLE_H);
    end
  end

  // Full-row detect on the row under scan; a full row holds the index so
  // the row that drops into it is examined next.
  always_comb begin
    row_full = 1'b0;
    if (int'(scan_row) < BOARD_H)
      row_full = &board[scan_row[Y_W-1:0]];
    scan_row_next = row_full ? scan_row : scan_row + 1'b1;
  end

  // Next board: set piece cells in LOCK, collapse a full row in SCAN.
  always_comb begin
    board_next = board;
    if (state == LOCK) begin
      for (int c = 0; c < 4; c++)
        if (cell_in[c]) board_next[cell_y[c]][cell_x[c]] = 1'b1;
    end
    if (state == SCAN && row_full) begin
      for (int i = 0; i < BOARD_H; i++)
        if (i >= int'(scan_row)) board_next[i] = board_up[i];
    end
  end

  // Sequencer next-state and strobes.
  always_comb begin
    state_next = state;
    lock_ready = 1'b0;
    clear_done = 1'b0;
    case (state)
      IDLE: begin
        lock_ready = 1'b1;
        if (lock_valid) state_next = LOCK;
      end
      LOCK: state_next = SCAN;
      // Leave once the index steps past the top row.
      SCAN: if (int'(scan_row_next) == BOARD_H) state_next = DONE;
      DONE: begin
        clear_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Board, lock latch, scan counters and sticky status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      board         <= '0;
      cell_x        <= '0;
      cell_y        <= '0;
      scan_row      <= '0;
      clr_cnt       <= '0;
      lines_cleared <= '0;
      top_out       <= 1'b0;
      bad_lock      <= 1'b0;
    end else begin
      board <= board_next;
      if (lock_valid && lock_ready) begin
        cell_x  <= lock_x;
        cell_y  <= lock_y;
        clr_cnt <= '0;
      end
      if (state == LOCK) begin
        scan_row <= '0;
        if (|cell_top) top_out  <= 1'b1;
        if (~&cell_in) bad_lock <= 1'b1;
      end
      if (state == SCAN) begin
        scan_row <= scan_row_next;
        if (row_full && clr_cnt != 3'd4) clr_cnt <= clr_cnt + 3'd1;
        // Final SCAN cycle never clears, so clr_cnt is already complete.
        if (state_next == DONE) lines_cleared <= clr_cnt;
      end
    end
  end

  // Four collision probes share the live board.
  for (genvar g = 0; g < 4; g++) begin : g_probe
    tetris_cell_probe #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H)) u_probe (
      .x     (query_x[g*X_W +: X_W]),
      .y     (query_y[g*Y_W +: Y_W]),
      .board (board),
      .hit   (probe_hit[g])
    );
  end

  // Registered query result and display row read-out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      query_hit       <= 1'b0;
      query_hit_valid <= 1'b0;
      rd_data         <= '0;
    end else begin
      query_hit_valid <= query_valid;
      query_hit       <= query_valid & (|probe_hit);
      rd_data         <= (int'(rd_row) < BOARD_H) ? board[rd_row] : '0;
    end
  end

endmodule

// File: tb/tb_tetris_playfield.sv
// Self-checking bench for tetris_playfield against a row-list board model.
module tb_tetris_playfield;

  localparam int W = 10, H = 23, VIS = 20;
  localparam int X_W = 4, Y_W = 5;
  localparam int LXW = 4*X_W, LYW = 4*Y_W;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           lock_valid, lock_ready;
  logic [LXW-1:0] lock_x;
  logic [LYW-1:0] lock_y;
  logic           query_valid;
  logic [LXW-1:0] query_x;
  logic [LYW-1:0] query_y;
  logic           query_hit, query_hit_valid;
  logic [Y_W-1:0] rd_row;
  logic [W-1:0]   rd_data;
  logic           clear_done;
  logic [2:0]     lines_cleared;
  logic           top_out, bad_lock;

  tetris_playfield #(.BOARD_W(W), .BOARD_H(H), .VISIBLE_H(VIS)) dut (
    .clock(clock), .reset(reset),
    .lock_valid(lock_valid), .lock_ready(lock_ready),
    .lock_x(lock_x), .lock_y(lock_y),
    .query_valid(query_valid), .query_x(query_x), .query_y(query_y),
    .query_hit(query_hit), .query_hit_valid(query_hit_valid),
    .rd_row(rd_row), .rd_data(rd_data),
    .clear_done(clear_done), .lines_cleared(lines_cleared),
    .top_out(top_out), .bad_lock(bad_lock)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: board as a list of rows, bottom first.
  bit [W-1:0] m_rows [H];
  bit         m_top, m_bad;
  int         m_lines;

  function automatic void model_reset();
    for (int r = 0; r < H; r++) m_rows[r] = '0;
    m_top = 0; m_bad = 0; m_lines = 0;
  endfunction

  // Place the cells, then drop every full row and let the rest fall.
  function automatic int model_lock(input int cx[4], input int cy[4]);
    bit [W-1:0] keep[$];
    int n;
    for (int c = 0; c < 4; c++) begin
      if (cx[c] < W && cy[c] < H) begin
        m_rows[cy[c]][cx[c]] = 1'b1;
        if (cy[c] >= VIS) m_top = 1;
      end else m_bad = 1;
    end
    for (int r = 0; r < H; r++)
      if (m_rows[r] != {W{1'b1}}) keep.push_back(m_rows[r]);
    n = H - keep.size();
    for (int r = 0; r < H; r++) m_rows[r] = (r < keep.size()) ? keep[r] : '0;
    m_lines = (n > 4) ? 4 : n;
    return n;
  endfunction

  function automatic bit model_hit(input int x, input int y);
    if (x >= W || y >= H) return 1'b1;
    return m_rows[y][x];
  endfunction

  task automatic do_reset();
    @(negedge clock);
    lock_valid = 0; query_valid = 0; rd_row = '0;
    reset = 1;
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    model_reset();
  endtask

  // Drives one lock and follows it to clear_done (bounded).
  task automatic drive_lock(input int cx[4], input int cy[4], output int cyc,
                            output bit tmo, output bit rdy_busy,
                            output logic [2:0] lines_o, output bit pulse_after,
                            output bit rdy_after);
    tmo = 1; cyc = 0; rdy_busy = 1; lines_o = '0; pulse_after = 1; rdy_after = 0;
    @(negedge clock);
    for (int c = 0; c < 4; c++) begin
      lock_x[c*X_W +: X_W] = X_W'(cx[c]);
      lock_y[c*Y_W +: Y_W] = Y_W'(cy[c]);
    end
    lock_valid = 1;
    for (int k = 0; k < 100 && !lock_ready; k++) @(negedge clock);
    if (!lock_ready) begin lock_valid = 0; return; end
    @(negedge clock);
    // Coordinates must have been captured; scramble them now.
    lock_valid = 0;
    lock_x = LXW'($urandom);
    lock_y = LYW'($urandom);
    rdy_busy = lock_ready;
    for (int k = 1; k <= 200; k++) begin
      if (clear_done) begin cyc = k; tmo = 0; lines_o = lines_cleared; break; end
      @(negedge clock);
    end
    if (!tmo) begin
      @(negedge clock);
      pulse_after = clear_done;
      rdy_after   = lock_ready;
    end
  endtask

  task automatic lock_and_check(input string tag, input int cx[4], input int cy[4],
                                output logic [2:0] lines_o);
    int cyc, n;
    bit tmo, rdy_busy, pulse_after, rdy_after;
    drive_lock(cx, cy, cyc, tmo, rdy_busy, lines_o, pulse_after, rdy_after);
    n = model_lock(cx, cy);
    n_assert++;
    if (tmo) begin
      n_fail++; $display("FAIL %s timeout: no clear_done, exp at cycle %0d", tag, 2+H+n);
    end else if (cyc !== 2+H+n) begin
      n_fail++; $display("FAIL %s latency: got %0d cycles exp %0d", tag, cyc, 2+H+n);
    end
    n_assert++;
    if (lines_o !== 3'(m_lines)) begin
      n_fail++; $display("FAIL %s lines_cleared: got %0d exp %0d", tag, lines_o, m_lines);
    end
    n_assert++;
    if (rdy_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s lock_ready busy: got %b exp 0", tag, rdy_busy);
    end
    n_assert++;
    if (pulse_after !== 1'b0 || rdy_after !== 1'b1) begin
      n_fail++; $display("FAIL %s after done: clear_done %b lock_ready %b exp 0 1", tag, pulse_after, rdy_after);
    end
    n_assert++;
    if (top_out !== m_top || bad_lock !== m_bad) begin
      n_fail++; $display("FAIL %s flags: top_out %b bad_lock %b exp %b %b", tag, top_out, bad_lock, m_top, m_bad);
    end
  endtask

  task automatic read_row(input int r, output logic [W-1:0] v);
    @(negedge clock);
    rd_row = Y_W'(r);
    @(negedge clock);
    v = rd_data;
  endtask

  task automatic check_board(input string tag);
    logic [W-1:0] v;
    for (int r = 0; r < H; r++) begin
      read_row(r, v);
      n_assert++;
      if (v !== m_rows[r]) begin
        n_fail++; $display("FAIL %s row %0d: got %h exp %h", tag, r, v, m_rows[r]);
      end
    end
  endtask

  task automatic do_query(input int qx[4], input int qy[4], output logic hit,
                          output logic hv, output logic hv_after);
    @(negedge clock);
    for (int c = 0; c < 4; c++) begin
      query_x[c*X_W +: X_W] = X_W'(qx[c]);
      query_y[c*Y_W +: Y_W] = Y_W'(qy[c]);
    end
    query_valid = 1;
    @(negedge clock);
    hit = query_hit; hv = query_hit_valid;
    query_valid = 0;
    @(negedge clock);
    hv_after = query_hit_valid;
  endtask

  task automatic test_reset();
    logic [18:0] got;
    got = {lock_ready, query_hit, query_hit_valid, clear_done, top_out, bad_lock, lines_cleared, rd_data};
    n_assert++;
    if (got !== {1'b1, 18'b0}) begin
      n_fail++; $display("FAIL reset_held outputs: got %h exp %h", got, {1'b1, 18'b0});
    end
    @(negedge clock);
    reset = 0;
    model_reset();
    @(negedge clock);
    got = {lock_ready, query_hit, query_hit_valid, clear_done, top_out, bad_lock, lines_cleared, rd_data};
    n_assert++;
    if (got !== {1'b1, 18'b0}) begin
      n_fail++; $display("FAIL reset_released outputs: got %h exp %h", got, {1'b1, 18'b0});
    end
    check_board("reset_board");
  endtask

  task automatic test_lock_basic();
    logic [2:0] l;
    logic [W-1:0] v;
    lock_and_check("basic", '{0,1,2,3}, '{0,0,0,0}, l);
    read_row(0, v);
    n_assert++;
    if (v !== 10'h00F) begin n_fail++; $display("FAIL basic row0: got %h exp 00f", v); end
    read_row(23, v);
    n_assert++;
    if (v !== 10'h000) begin n_fail++; $display("FAIL basic rd_row23: got %h exp 000", v); end
    read_row(31, v);
    n_assert++;
    if (v !== 10'h000) begin n_fail++; $display("FAIL basic rd_row31: got %h exp 000", v); end
  endtask

  task automatic test_single_clear();
    logic [2:0] l;
    logic [W-1:0] v;
    lock_and_check("single_pre", '{4,5,0,1}, '{0,0,1,1}, l);
    lock_and_check("single", '{6,7,8,9}, '{0,0,0,0}, l);
    n_assert++;
    if (l !== 3'd1) begin n_fail++; $display("FAIL single lines: got %0d exp 1", l); end
    read_row(0, v);
    n_assert++;
    if (v !== 10'h003) begin n_fail++; $display("FAIL single row0: got %h exp 003", v); end
    read_row(22, v);
    n_assert++;
    if (v !== 10'h000) begin n_fail++; $display("FAIL single row22: got %h exp 000", v); end
    check_board("single_board");
  endtask

  task automatic test_quad_clear();
    logic [2:0] l;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      lock_and_check("quad_fill", '{0,1,2,3}, '{r,r,r,r}, l);
      lock_and_check("quad_fill", '{4,5,6,7}, '{r,r,r,r}, l);
      lock_and_check("quad_fill", '{8,8,8,8}, '{r,r,r,r}, l);
    end
    lock_and_check("quad", '{9,9,9,9}, '{0,1,2,3}, l);
    n_assert++;
    if (l !== 3'd4) begin n_fail++; $display("FAIL quad lines: got %0d exp 4", l); end
    check_board("quad_board");
  endtask

  task automatic test_query();
    logic hit, hv, hv2;
    logic [2:0] l;
    int qx[4], qy[4];
    bit exp;
    do_reset();
    do_query('{0,10,3,4}, '{0,5,31,4}, hit, hv, hv2);
    n_assert++;
    if (hit !== 1'b1 || hv !== 1'b1 || hv2 !== 1'b0) begin
      n_fail++; $display("FAIL query_mixed: hit %b valid %b valid_after %b exp 1 1 0", hit, hv, hv2);
    end
    do_query('{4,4,4,4}, '{4,4,4,4}, hit, hv, hv2);
    n_assert++;
    if (hit !== 1'b0 || hv !== 1'b1) begin
      n_fail++; $display("FAIL query_empty: hit %b valid %b exp 0 1", hit, hv);
    end
    do_query('{10,10,10,10}, '{5,5,5,5}, hit, hv, hv2);
    n_assert++;
    if (hit !== 1'b1) begin n_fail++; $display("FAIL query_x10: hit %b exp 1", hit); end
    do_query('{3,3,3,3}, '{31,31,31,31}, hit, hv, hv2);
    n_assert++;
    if (hit !== 1'b1) begin n_fail++; $display("FAIL query_ywrap: hit %b exp 1", hit); end
    lock_and_check("query_lock", '{2,3,4,5}, '{1,1,1,2}, l);
    for (int i = 0; i < 24; i++) begin
      for (int c = 0; c < 4; c++) begin
        qx[c] = $urandom_range(0, 11);
        qy[c] = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 3);
        if (i[0]) begin qx[c] = qx[0]; qy[c] = qy[0]; end
      end
      exp = 0;
      for (int c = 0; c < 4; c++) exp |= model_hit(qx[c], qy[c]);
      do_query(qx, qy, hit, hv, hv2);
      n_assert++;
      if (hit !== exp || hv !== 1'b1) begin
        n_fail++; $display("FAIL query_rand %0d: hit %b valid %b exp %b 1", i, hit, hv, exp);
      end
    end
  endtask

  task automatic test_topout_badlock();
    logic [2:0] l;
    logic [W-1:0] v;
    do_reset();
    lock_and_check("top", '{5,5,5,5}, '{20,20,20,20}, l);
    n_assert++;
    if (top_out !== 1'b1 || bad_lock !== 1'b0) begin
      n_fail++; $display("FAIL top flags: top_out %b bad_lock %b exp 1 0", top_out, bad_lock);
    end
    read_row(20, v);
    n_assert++;
    if (v !== 10'h020) begin n_fail++; $display("FAIL top row20: got %h exp 020", v); end
    lock_and_check("bad", '{12,0,1,2}, '{0,0,0,0}, l);
    n_assert++;
    if (top_out !== 1'b1 || bad_lock !== 1'b1) begin
      n_fail++; $display("FAIL bad flags: top_out %b bad_lock %b exp 1 1", top_out, bad_lock);
    end
    read_row(0, v);
    n_assert++;
    if (v !== 10'h007) begin n_fail++; $display("FAIL bad row0: got %h exp 007", v); end
    lock_and_check("sticky", '{0,1,2,3}, '{1,1,1,1}, l);
    n_assert++;
    if (top_out !== 1'b1 || bad_lock !== 1'b1) begin
      n_fail++; $display("FAIL sticky flags: top_out %b bad_lock %b exp 1 1", top_out, bad_lock);
    end
    check_board("top_board");
  endtask

  task automatic test_random();
    logic [2:0] l;
    int cx[4], cy[4];
    int y0, sel;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      y0 = $urandom_range(0, 1);
      for (int c = 0; c < 4; c++) begin
        sel = $urandom_range(0, 19);
        if (sel == 0) begin
          cx[c] = $urandom_range(10, 15); cy[c] = y0;
        end else if (sel == 1) begin
          cx[c] = $urandom_range(0, 9);   cy[c] = $urandom_range(18, 31);
        end else begin
          cx[c] = $urandom_range(0, 9);   cy[c] = y0 + $urandom_range(0, 1);
        end
      end
      lock_and_check("rand", cx, cy, l);
      check_board("rand_board");
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [2:0] l;
    logic [18:0] got;
    int pulses;
    do_reset();
    lock_and_check("mid_pre", '{0,1,2,3}, '{0,0,0,0}, l);
    lock_and_check("mid_pre", '{4,5,6,7}, '{0,0,0,0}, l);
    lock_and_check("mid_pre", '{8,9,0,12}, '{0,0,20,0}, l);
    @(negedge clock);
    for (int c = 0; c < 4; c++) begin
      lock_x[c*X_W +: X_W] = X_W'(c);
      lock_y[c*Y_W +: Y_W] = '0;
    end
    lock_valid = 1;
    query_valid = 1; query_x = '1; query_y = '0;
    rd_row = '0;
    @(negedge clock);
    lock_valid = 0;
    repeat (5) @(negedge clock);
    got = {lock_ready, query_hit, query_hit_valid, clear_done, top_out, bad_lock, lines_cleared, rd_data};
    n_assert++;
    if (got !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 10'h00F}) begin
      n_fail++; $display("FAIL mid_scan pre-reset: got %h exp %h", got, {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 10'h00F});
    end
    #2 reset = 1;
    #1;
    got = {lock_ready, query_hit, query_hit_valid, clear_done, top_out, bad_lock, lines_cleared, rd_data};
    n_assert++;
    if (got !== {1'b1, 18'b0}) begin
      n_fail++; $display("FAIL mid_scan async reset: got %h exp %h", got, {1'b1, 18'b0});
    end
    query_valid = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    model_reset();
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (clear_done) pulses++;
    end
    n_assert++;
    if (pulses !== 0) begin n_fail++; $display("FAIL mid_scan clear_done pulses: got %0d exp 0", pulses); end
    check_board("mid_scan_board");
  endtask

  initial begin
    lock_valid = 0; lock_x = '0; lock_y = '0;
    query_valid = 0; query_x = '0; query_y = '0;
    rd_row = '0;
    model_reset();
    #1 reset = 1;
    #3;
    test_reset();
    test_lock_basic();
    test_single_clear();
    test_quad_clear();
    test_query();
    test_topout_badlock();
    test_random();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tetris_playfield.md
TETRIS_PLAYFIELD -- requirements
Module: tetris_playfield

Interface
REQ-001 Parameter BOARD_W, default 10, playfield columns.
REQ-002 Parameter BOARD_H, default 23, playfield rows including spawn rows; row 0 is the bottom.
REQ-003 Parameter VISIBLE_H, default 20, rows below this index are in play; a lock at or above it is top-out.
REQ-004 Derived X_W = clog2(BOARD_W), Y_W = clog2(BOARD_H), not overridable.
REQ-005 clock  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state.
REQ-007 lock_valid  in  1  request to commit four piece cells to the board.
REQ-008 lock_ready  out  1  high only in IDLE; a lock is accepted when lock_valid and lock_ready are both high at an edge.
REQ-009 lock_x  in  4*X_W  packed cell columns, cell 0 in the LSBs; lock_y  in  4*Y_W  packed cell rows, same packing.
REQ-010 query_valid  in  1  collision probe strobe; query_x  in  4*X_W; query_y  in  4*Y_W, packed as lock.
REQ-011 query_hit  out  1  registered: any probed cell occupied or out of range; query_hit_valid  out  1  qualifies it.
REQ-012 rd_row  in  Y_W  display read row; rd_data  out  BOARD_W  registered contents of that row, bit n = column n.
REQ-013 clear_done  out  1  one-cycle pulse when a lock/clear sequence completes; lines_cleared  out  3  rows removed by it (0-4), held until next clear_done.
REQ-014 top_out  out  1  sticky game-over flag; bad_lock  out  1  sticky flag for any locked cell out of range.

Function
REQ-015 FSM states IDLE, LOCK, SCAN, DONE; IDLE->LOCK on accepted lock; LOCK->SCAN after one cycle; SCAN->DONE once scan row index equals BOARD_H; DONE->IDLE after one cycle.
REQ-016 In LOCK the block shall set the four latched cells; cells with x>=BOARD_W or y>=BOARD_H are not written and set bad_lock.
REQ-017 In LOCK, any in-range cell with y>=VISIBLE_H shall set top_out.
REQ-018 In SCAN, one row r per cycle starting at 0: if row r is all ones, rows r..BOARD_H-2 take the contents of the row above, row BOARD_H-1 becomes zero, r holds, and the clear count increments; otherwise r increments.
REQ-019 A lock with N full rows shall spend exactly 1 LOCK + BOARD_H+N SCAN + 1 DONE cycles; clear_done is high in the DONE cycle and lines_cleared updates at that DONE-cycle edge.
REQ-020 Duplicate cells in one lock shall be harmless; the clear count saturates at 4.
REQ-021 Lock coordinates shall be captured at the accepting edge; later input changes have no effect.
REQ-022 Query shall be accepted in every state; query_hit and query_hit_valid appear one cycle after query_valid and reflect the board before that edge's update.
REQ-023 Any probed cell with x>=BOARD_W or y>=BOARD_H (including unsigned wrap of y=0 minus 1) shall report hit.
REQ-024 rd_data shall have one-cycle latency from rd_row, reflect pre-edge board contents, and read zero for rd_row>=BOARD_H.
REQ-025 top_out and bad_lock clear only on reset; top_out does not block further locks.

Reset
REQ-026 On reset: board all zero, FSM IDLE, lock_ready 1, query_hit 0, query_hit_valid 0, rd_data 0, clear_done 0, lines_cleared 0, top_out 0, bad_lock 0.
REQ-027 Reset asserted mid-sequence shall abandon it immediately with no clear_done pulse.

Structure
REQ-028 Package tetris_pkg shall hold the FSM state enum and the default BOARD_W/BOARD_H/VISIBLE_H constants.
REQ-029 One sub-module, tetris_cell_probe (single cell x,y plus board -> occupied-or-out-of-range), shall be instanced four times for query.

Verification
REQ-030 Empty board, lock (0,0),(1,0),(2,0),(3,0) -> clear_done 1+23+1 cycles after LOCK entry, lines_cleared 0, rd_row 0 = 0x00F.
REQ-031 Row 0 holds columns 0-5; lock (6..9,0) -> lines_cleared 1, row 0 takes old row 1, row 22 = 0, SCAN lasts 24 cycles.
REQ-032 Rows 0-3 pre-filled except column 9; lock I-piece (9,0..3) -> lines_cleared 4, board all zero.
REQ-033 Query (0,0)/(10,5)/(3,31)/(4,4) on empty board -> query_hit 1 next cycle; all cells at (4,4) on empty board -> 0.
REQ-034 Lock a cell at y=20 -> top_out 1 and sticky; lock a cell at x=12 -> bad_lock 1, cell not written.
REQ-035 Assert reset during SCAN -> all outputs at reset values asynchronously, no clear_done pulse.
